// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multicycle RISC-V control unit: state encoding,
// opcode/funct3 constants, datapath select encodings and the Moore output bundle.
package multicycle_ctrl_pkg;

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAdr   = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StExecR    = 4'd6,
    StExecI    = 4'd7,
    StAluWb    = 4'd8,
    StBranch   = 4'd9,
    StJal      = 4'd10,
    StJalr     = 4'd11,
    StJalrWb   = 4'd12,
    StTrap     = 4'd13
  } state_e;

  // Opcodes (IR[6:0])
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpRtype  = 7'b0110011;
  localparam logic [6:0] OpItype  = 7'b0010011;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;

  // Branch funct3 (IR[14:12])
  localparam logic [2:0] F3Beq = 3'b000;
  localparam logic [2:0] F3Bne = 3'b001;

  // ALU operand A select
  localparam logic [1:0] SrcAPc    = 2'b00;
  localparam logic [1:0] SrcAOldPc = 2'b01;
  localparam logic [1:0] SrcARs1   = 2'b10;
  localparam logic [1:0] SrcAZero  = 2'b11;

  // ALU operand B select
  localparam logic [1:0] SrcBRs2  = 2'b00;
  localparam logic [1:0] SrcBFour = 2'b01;
  localparam logic [1:0] SrcBImm  = 2'b10;

  // ALU operation
  localparam logic [1:0] AluAdd   = 2'b00;
  localparam logic [1:0] AluSub   = 2'b01;
  localparam logic [1:0] AluFunct = 2'b10;

  // Result mux select
  localparam logic [1:0] ResAluOut = 2'b00;
  localparam logic [1:0] ResMem    = 2'b01;
  localparam logic [1:0] ResAlu    = 2'b10;

  // Moore outputs plus qualifier flags that the top combines with
  // mem_ready / zero to form the few input-dependent outputs.
  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       adr_src;
    logic       reg_write;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] result_src;
    logic       pc_write_always;
    logic       pc_write_on_ready;
    logic       ir_write_on_ready;
    logic       branch_eq;
    logic       branch_ne;
    logic       done_always;
    logic       done_on_ready;
  } ctrl_out_t;

endpackage

// File: rtl/multicycle_ctrl_out_decode.sv
// ctrl_out_decode: combinational state-to-output table for the multicycle
// control unit.
//   state_i  - current FSM state
//   op_i     - opcode latched in DECODE
//   funct3_i - funct3 latched in DECODE
//   ctrl_o   - Moore outputs and qualifier flags (unset fields are 0)
module ctrl_out_decode
  import multicycle_ctrl_pkg::*;
(
  input  state_e     state_i,
  input  logic [6:0] op_i,
  input  logic [2:0] funct3_i,
  output ctrl_out_t  ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    unique case (state_i)
      StFetch: begin
        ctrl_o.mem_read          = 1'b1;
        ctrl_o.adr_src           = 1'b0;
        ctrl_o.alu_src_a         = SrcAPc;
        ctrl_o.alu_src_b         = SrcBFour;
        ctrl_o.alu_op            = AluAdd;
        ctrl_o.result_src        = ResAlu;
        ctrl_o.ir_write_on_ready = 1'b1;
        ctrl_o.pc_write_on_ready = 1'b1;
      end
      StDecode: begin
        // Branch/JAL target computed speculatively into ALUOut.
        ctrl_o.alu_src_a = SrcAOldPc;
        ctrl_o.alu_src_b = SrcBImm;
        ctrl_o.alu_op    = AluAdd;
      end
      StMemAdr: begin
        ctrl_o.alu_src_a = SrcARs1;
        ctrl_o.alu_src_b = SrcBImm;
        ctrl_o.alu_op    = AluAdd;
      end
      StMemRead: begin
        ctrl_o.mem_read = 1'b1;
        ctrl_o.adr_src  = 1'b1;
      end
      StMemWb: begin
        ctrl_o.reg_write   = 1'b1;
        ctrl_o.result_src  = ResMem;
        ctrl_o.done_always = 1'b1;
      end
      StMemWrite: begin
        ctrl_o.mem_write     = 1'b1;
        ctrl_o.adr_src       = 1'b1;
        ctrl_o.done_on_ready = 1'b1;
      end
      StExecR: begin
        ctrl_o.alu_src_a = SrcARs1;
        ctrl_o.alu_src_b = SrcBRs2;
        ctrl_o.alu_op    = AluFunct;
      end
      StExecI: begin
        ctrl_o.alu_src_b = SrcBImm;
        if (op_i == OpLui) begin
          // LUI: 0 + imm
          ctrl_o.alu_src_a = SrcAZero;
          ctrl_o.alu_op    = AluAdd;
        end else begin
          ctrl_o.alu_src_a = SrcARs1;
          ctrl_o.alu_op    = AluFunct;
        end
      end
      StAluWb: begin
        ctrl_o.reg_write   = 1'b1;
        ctrl_o.result_src  = ResAluOut;
        ctrl_o.done_always = 1'b1;
      end
      StBranch: begin
        ctrl_o.alu_src_a  = SrcARs1;
        ctrl_o.alu_src_b  = SrcBRs2;
        ctrl_o.alu_op     = AluSub;
        ctrl_o.result_src = ResAluOut;
        // Unsupported funct3 leaves pc_write/instr_done low; the FSM traps.
        if (funct3_i == F3Beq) begin
          ctrl_o.branch_eq   = 1'b1;
          ctrl_o.done_always = 1'b1;
        end else if (funct3_i == F3Bne) begin
          ctrl_o.branch_ne   = 1'b1;
          ctrl_o.done_always = 1'b1;
        end
      end
      StJal: begin
        ctrl_o.alu_src_a       = SrcAOldPc;
        ctrl_o.alu_src_b       = SrcBFour;
        ctrl_o.alu_op          = AluAdd;
        ctrl_o.result_src      = ResAluOut;
        ctrl_o.pc_write_always = 1'b1;
      end
      StJalr: begin
        ctrl_o.alu_src_a       = SrcARs1;
        ctrl_o.alu_src_b       = SrcBImm;
        ctrl_o.alu_op          = AluAdd;
        ctrl_o.result_src      = ResAlu;
        ctrl_o.pc_write_always = 1'b1;
      end
      StJalrWb: begin
        ctrl_o.alu_src_a   = SrcAOldPc;
        ctrl_o.alu_src_b   = SrcBFour;
        ctrl_o.alu_op      = AluAdd;
        ctrl_o.result_src  = ResAlu;
        ctrl_o.reg_write   = 1'b1;
        ctrl_o.done_always = 1'b1;
      end
      default: ctrl_o = '0;  // StTrap and unused codes: all enables off
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: control FSM for a multicycle RISC-V datapath.
//   clk, reset         - clock and synchronous active-high reset
//   opcode, funct3     - instruction fields straight from IR
//   zero               - ALU result is zero (branch compare)
//   mem_ready          - memory access completes this cycle
//   pc_write .. result_src - datapath enables and mux selects
//   instr_done         - one-cycle pulse in the final state of an instruction
//   illegal            - sticky trap flag, cleared only by reset
//   state              - current state for debug
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       adr_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] result_src,
  output logic       instr_done,
  output logic       illegal,
  output logic [3:0] state
);

  state_e     state_q, state_d;
  logic [6:0] op_q;
  logic [2:0] funct3_q;
  logic       illegal_q;
  ctrl_out_t  ctrl;
  logic       run;

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFetch:    if (mem_ready) state_d = StDecode;
      StDecode: begin
        // IR was loaded at the end of FETCH, so the live opcode is valid here.
        case (opcode)
          OpLoad, OpStore: state_d = StMemAdr;
          OpRtype:         state_d = StExecR;
          OpItype, OpLui:  state_d = StExecI;
          OpBranch:        state_d = StBranch;
          OpJal:           state_d = StJal;
          OpJalr:          state_d = StJalr;
          default:         state_d = StTrap;
        endcase
      end
      StMemAdr:   state_d = (op_q == OpLoad) ? StMemRead : StMemWrite;
      StMemRead:  if (mem_ready) state_d = StMemWb;
      StMemWb:    state_d = StFetch;
      StMemWrite: if (mem_ready) state_d = StFetch;
      StExecR:    state_d = StAluWb;
      StExecI:    state_d = StAluWb;
      StAluWb:    state_d = StFetch;
      StBranch: begin
        if (funct3_q == F3Beq || funct3_q == F3Bne) state_d = StFetch;
        else                                        state_d = StTrap;
      end
      StJal:      state_d = StAluWb;
      StJalr:     state_d = StJalrWb;
      StJalrWb:   state_d = StFetch;
      StTrap:     state_d = StTrap;
      default:    state_d = StTrap;
    endcase
  end

  // State register, instruction-field latch and sticky illegal flag
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StFetch;
      op_q      <= '0;
      funct3_q  <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == StDecode) begin
        op_q     <= opcode;
        funct3_q <= funct3;
      end
      if (state_d == StTrap) illegal_q <= 1'b1;
    end
  end

  ctrl_out_decode u_out_decode (
    .state_i  (state_q),
    .op_i     (op_q),
    .funct3_i (funct3_q),
    .ctrl_o   (ctrl)
  );

  // Reset masks every output so a reset cycle cannot fire any side effect.
  assign run = ~reset;

  assign pc_write   = run & (ctrl.pc_write_always
                           | (ctrl.pc_write_on_ready & mem_ready)
                           | (ctrl.branch_eq & zero)
                           | (ctrl.branch_ne & ~zero));
  assign ir_write   = run & ctrl.ir_write_on_ready & mem_ready;
  assign reg_write  = run & ctrl.reg_write;
  assign mem_read   = run & ctrl.mem_read;
  assign mem_write  = run & ctrl.mem_write;
  assign adr_src    = run & ctrl.adr_src;
  assign alu_src_a  = run ? ctrl.alu_src_a  : 2'b00;
  assign alu_src_b  = run ? ctrl.alu_src_b  : 2'b00;
  assign alu_op     = run ? ctrl.alu_op     : 2'b00;
  assign result_src = run ? ctrl.result_src : 2'b00;
  assign instr_done = run & (ctrl.done_always | (ctrl.done_on_ready & mem_ready));
  assign illegal    = run & illegal_q;
  assign state      = run ? state_q : StFetch;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench: each stimulus cycle pushes its hand-computed expected output
// vector; a negedge monitor pops and compares against the DUT outputs.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] opcode = '0;
  logic [2:0] funct3 = '0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       pc_write, ir_write, reg_write, mem_read, mem_write, adr_src;
  logic [1:0] alu_src_a, alu_src_b, alu_op, result_src;
  logic       instr_done, illegal;
  logic [3:0] state;

  int errors = 0;
  int checks = 0;

  string       name_q[$];
  logic [19:0] exp_q[$];

  always #5 clk = ~clk;

  multicycle_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .opcode     (opcode),
    .funct3     (funct3),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .pc_write   (pc_write),
    .ir_write   (ir_write),
    .reg_write  (reg_write),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .adr_src    (adr_src),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .result_src (result_src),
    .instr_done (instr_done),
    .illegal    (illegal),
    .state      (state)
  );

  // {pc_write, ir_write, reg_write, mem_read, mem_write, adr_src,
  //  alu_src_a, alu_src_b, alu_op, result_src, instr_done, illegal, state}
  function automatic logic [19:0] ev(input logic pcw, input logic irw, input logic rw,
                                     input logic mr, input logic mw, input logic adr,
                                     input logic [1:0] a, input logic [1:0] b,
                                     input logic [1:0] op, input logic [1:0] res,
                                     input logic done, input logic ill,
                                     input logic [3:0] st);
    return {pcw, irw, rw, mr, mw, adr, a, b, op, res, done, ill, st};
  endfunction

  // Hand-computed expectations; state codes: FETCH 0, DECODE 1, MEMADR 2,
  // MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, EXECI 7, ALUWB 8, BRANCH 9,
  // JAL 10, JALR 11, JALRWB 12, TRAP 13.
  localparam logic [19:0] ERst     = ev(0,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00, 0,0, 4'd0);
  localparam logic [19:0] EFetchR  = ev(1,1,0,1,0,0, 2'b00,2'b01,2'b00,2'b10, 0,0, 4'd0);
  localparam logic [19:0] EFetchW  = ev(0,0,0,1,0,0, 2'b00,2'b01,2'b00,2'b10, 0,0, 4'd0);
  localparam logic [19:0] EDecode  = ev(0,0,0,0,0,0, 2'b01,2'b10,2'b00,2'b00, 0,0, 4'd1);
  localparam logic [19:0] EMemAdr  = ev(0,0,0,0,0,0, 2'b10,2'b10,2'b00,2'b00, 0,0, 4'd2);
  localparam logic [19:0] EMemRead = ev(0,0,0,1,0,1, 2'b00,2'b00,2'b00,2'b00, 0,0, 4'd3);
  localparam logic [19:0] EMemWb   = ev(0,0,1,0,0,0, 2'b00,2'b00,2'b00,2'b01, 1,0, 4'd4);
  localparam logic [19:0] EMemWrR  = ev(0,0,0,0,1,1, 2'b00,2'b00,2'b00,2'b00, 1,0, 4'd5);
  localparam logic [19:0] EMemWrW  = ev(0,0,0,0,1,1, 2'b00,2'b00,2'b00,2'b00, 0,0, 4'd5);
  localparam logic [19:0] EExecR   = ev(0,0,0,0,0,0, 2'b10,2'b00,2'b10,2'b00, 0,0, 4'd6);
  localparam logic [19:0] EExecI   = ev(0,0,0,0,0,0, 2'b10,2'b10,2'b10,2'b00, 0,0, 4'd7);
  localparam logic [19:0] EExecLui = ev(0,0,0,0,0,0, 2'b11,2'b10,2'b00,2'b00, 0,0, 4'd7);
  localparam logic [19:0] EAluWb   = ev(0,0,1,0,0,0, 2'b00,2'b00,2'b00,2'b00, 1,0, 4'd8);
  localparam logic [19:0] EBrTaken = ev(1,0,0,0,0,0, 2'b10,2'b00,2'b01,2'b00, 1,0, 4'd9);
  localparam logic [19:0] EBrNot   = ev(0,0,0,0,0,0, 2'b10,2'b00,2'b01,2'b00, 1,0, 4'd9);
  localparam logic [19:0] EBrBad   = ev(0,0,0,0,0,0, 2'b10,2'b00,2'b01,2'b00, 0,0, 4'd9);
  localparam logic [19:0] EJal     = ev(1,0,0,0,0,0, 2'b01,2'b01,2'b00,2'b00, 0,0, 4'd10);
  localparam logic [19:0] EJalr    = ev(1,0,0,0,0,0, 2'b10,2'b10,2'b00,2'b10, 0,0, 4'd11);
  localparam logic [19:0] EJalrWb  = ev(0,0,1,0,0,0, 2'b01,2'b01,2'b00,2'b10, 1,0, 4'd12);
  localparam logic [19:0] ETrap    = ev(0,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00, 0,1, 4'd13);

  localparam logic [6:0] LD  = 7'b0000011;
  localparam logic [6:0] ST  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] LUI = 7'b0110111;
  localparam logic [6:0] BR  = 7'b1100011;
  localparam logic [6:0] JL  = 7'b1101111;
  localparam logic [6:0] JR  = 7'b1100111;
  localparam logic [6:0] BAD = 7'b1111111;

  // One cycle of stimulus plus its expected response.
  task automatic step(input string nm, input logic rst, input logic [6:0] op,
                      input logic [2:0] f3, input logic z, input logic mr,
                      input logic [19:0] e);
    @(posedge clk);
    #1;
    reset     = rst;
    opcode    = op;
    funct3    = f3;
    zero      = z;
    mem_ready = mr;
    name_q.push_back(nm);
    exp_q.push_back(e);
  endtask

  // Monitor: compare once per cycle, away from the active edge.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      string       nm;
      logic [19:0] e;
      logic [19:0] got;
      nm  = name_q.pop_front();
      e   = exp_q.pop_front();
      got = {pc_write, ir_write, reg_write, mem_read, mem_write, adr_src,
             alu_src_a, alu_src_b, alu_op, result_src, instr_done, illegal, state};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL %s: got %05h required %05h", nm, got, e);
      end
    end
  end

  initial begin
    step("reset",        1, RT, 3'b000, 0, 1, ERst);
    // add
    step("add.fetch",    0, RT, 3'b000, 0, 1, EFetchR);
    step("add.decode",   0, RT, 3'b000, 0, 1, EDecode);
    step("add.execr",    0, RT, 3'b000, 0, 1, EExecR);
    step("add.aluwb",    0, RT, 3'b000, 0, 1, EAluWb);
    // lw with fetch stall and 3 MEMREAD stall cycles
    step("lw.fetchwait", 0, LD, 3'b010, 0, 0, EFetchW);
    step("lw.fetch",     0, LD, 3'b010, 0, 1, EFetchR);
    step("lw.decode",    0, LD, 3'b010, 0, 1, EDecode);
    step("lw.memadr",    0, LD, 3'b010, 0, 1, EMemAdr);
    step("lw.memrd0",    0, LD, 3'b010, 0, 0, EMemRead);
    step("lw.memrd1",    0, LD, 3'b010, 0, 0, EMemRead);
    step("lw.memrd2",    0, LD, 3'b010, 0, 0, EMemRead);
    step("lw.memrd3",    0, LD, 3'b010, 0, 1, EMemRead);
    step("lw.memwb",     0, LD, 3'b010, 0, 1, EMemWb);
    // sw with one write stall
    step("sw.fetch",     0, ST, 3'b010, 0, 1, EFetchR);
    step("sw.decode",    0, ST, 3'b010, 0, 1, EDecode);
    step("sw.memadr",    0, ST, 3'b010, 0, 1, EMemAdr);
    step("sw.memwrwait", 0, ST, 3'b010, 0, 0, EMemWrW);
    step("sw.memwr",     0, ST, 3'b010, 0, 1, EMemWrR);
    // addi, lui
    step("addi.fetch",   0, IT, 3'b000, 0, 1, EFetchR);
    step("addi.decode",  0, IT, 3'b000, 0, 1, EDecode);
    step("addi.execi",   0, IT, 3'b000, 0, 1, EExecI);
    step("addi.aluwb",   0, IT, 3'b000, 0, 1, EAluWb);
    step("lui.fetch",    0, LUI, 3'b000, 0, 1, EFetchR);
    step("lui.decode",   0, LUI, 3'b000, 0, 1, EDecode);
    step("lui.execi",    0, LUI, 3'b000, 0, 1, EExecLui);
    step("lui.aluwb",    0, LUI, 3'b000, 0, 1, EAluWb);
    // beq/bne both ways
    step("beq1.fetch",   0, BR, 3'b000, 1, 1, EFetchR);
    step("beq1.decode",  0, BR, 3'b000, 1, 1, EDecode);
    step("beq1.branch",  0, BR, 3'b000, 1, 1, EBrTaken);
    step("beq0.fetch",   0, BR, 3'b000, 0, 1, EFetchR);
    step("beq0.decode",  0, BR, 3'b000, 0, 1, EDecode);
    step("beq0.branch",  0, BR, 3'b000, 0, 1, EBrNot);
    step("bne1.fetch",   0, BR, 3'b001, 1, 1, EFetchR);
    step("bne1.decode",  0, BR, 3'b001, 1, 1, EDecode);
    step("bne1.branch",  0, BR, 3'b001, 1, 1, EBrNot);
    step("bne0.fetch",   0, BR, 3'b001, 0, 1, EFetchR);
    step("bne0.decode",  0, BR, 3'b001, 0, 1, EDecode);
    step("bne0.branch",  0, BR, 3'b001, 0, 1, EBrTaken);
    // jal, jalr
    step("jal.fetch",    0, JL, 3'b000, 0, 1, EFetchR);
    step("jal.decode",   0, JL, 3'b000, 0, 1, EDecode);
    step("jal.jal",      0, JL, 3'b000, 0, 1, EJal);
    step("jal.aluwb",    0, JL, 3'b000, 0, 1, EAluWb);
    step("jalr.fetch",   0, JR, 3'b000, 0, 1, EFetchR);
    step("jalr.decode",  0, JR, 3'b000, 0, 1, EDecode);
    step("jalr.jalr",    0, JR, 3'b000, 0, 1, EJalr);
    step("jalr.jalrwb",  0, JR, 3'b000, 0, 1, EJalrWb);
    // reset mid-MEMWRITE, then a clean add
    step("swr.fetch",    0, ST, 3'b010, 0, 1, EFetchR);
    step("swr.decode",   0, ST, 3'b010, 0, 1, EDecode);
    step("swr.memadr",   0, ST, 3'b010, 0, 1, EMemAdr);
    step("swr.memwr",    0, ST, 3'b010, 0, 0, EMemWrW);
    step("swr.reset",    1, ST, 3'b010, 0, 1, ERst);
    step("swr.after",    0, RT, 3'b000, 0, 1, EFetchR);
    step("swr.decode2",  0, RT, 3'b000, 0, 1, EDecode);
    step("swr.execr",    0, RT, 3'b000, 0, 1, EExecR);
    step("swr.aluwb",    0, RT, 3'b000, 0, 1, EAluWb);
    // reset mid-MEMREAD
    step("lwr.fetch",    0, LD, 3'b010, 0, 1, EFetchR);
    step("lwr.decode",   0, LD, 3'b010, 0, 1, EDecode);
    step("lwr.memadr",   0, LD, 3'b010, 0, 1, EMemAdr);
    step("lwr.memrd",    0, LD, 3'b010, 0, 0, EMemRead);
    step("lwr.reset",    1, LD, 3'b010, 0, 1, ERst);
    step("lwr.after",    0, LD, 3'b010, 0, 0, EFetchW);
    // branch with unsupported funct3 traps
    step("bbad.fetch",   0, BR, 3'b010, 1, 1, EFetchR);
    step("bbad.decode",  0, BR, 3'b010, 1, 1, EDecode);
    step("bbad.branch",  0, BR, 3'b010, 1, 1, EBrBad);
    step("bbad.trap0",   0, BR, 3'b010, 1, 1, ETrap);
    step("bbad.trap1",   0, BR, 3'b010, 1, 1, ETrap);
    step("bbad.reset",   1, BR, 3'b010, 1, 1, ERst);
    step("bbad.after",   0, RT, 3'b000, 0, 1, EFetchR);
    // unsupported opcode: trap held, then reset recovers
    step("ill.decode",   0, BAD, 3'b000, 0, 1, EDecode);
    for (int i = 0; i < 11; i++) step("ill.trap", 0, BAD, 3'b000, 0, 1, ETrap);
    step("ill.reset",    1, BAD, 3'b000, 0, 1, ERst);
    step("ill.after",    0, RT, 3'b000, 0, 1, EFetchR);
    step("ill.decode2",  0, RT, 3'b000, 0, 1, EDecode);

    @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
